// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU writeback definitions: default widths and the arbiter priority states.
// Pure declarations; no logic, latency or flow control of its own.
package regfile_wb_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle: ALU/load requests, issue/hazard lookup and register-file write port.
// Requesters hold valid/addr/data until they see ready; the write port has no backpressure.
interface regfile_wb_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output issue_valid, issue_addr,
        output rs1_addr, rs2_addr,
        input  alu_ready, mem_ready,
        input  rs1_busy, rs2_busy,
        input  reg_write, write_addr, write_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  issue_valid, issue_addr,
        input  rs1_addr, rs2_addr,
        output alu_ready, mem_ready,
        output rs1_busy, rs2_busy,
        output reg_write, write_addr, write_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on commit.
// Lookups are combinational; a set landing on the same edge as a clear wins. No backpressure.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid) begin
            set_mask[issue_addr] = 1'b1;
        end
        if (clr_valid) begin
            clr_mask[clr_addr] = 1'b1;
        end
        // Clear before set so a re-issue on the commit edge keeps the bit;
        // r0 is hardwired, so its bit never leaves zero.
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/load) register-file writeback arbiter with alternating priority and hazard scoreboard.
// Grant is same-cycle combinational, write lands 1 cycle later; the loser stalls holding its request.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  wb
);

    prio_t                 prio_q;
    prio_t                 prio_d;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  win_valid;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d    = prio_q;
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        win_valid = 1'b0;
        win_addr  = wb.alu_addr;
        win_data  = wb.alu_data;
        if (!rst) begin
            if (wb.alu_valid && (!wb.mem_valid || prio_q == PRIO_ALU)) begin
                alu_grant = 1'b1;
            end else if (wb.mem_valid) begin
                mem_grant = 1'b1;
            end
        end
        // Priority passes to whichever side did not just win.
        if (alu_grant) begin
            prio_d    = PRIO_MEM;
            win_valid = 1'b1;
        end else if (mem_grant) begin
            prio_d    = PRIO_ALU;
            win_valid = 1'b1;
            win_addr  = wb.mem_addr;
            win_data  = wb.mem_data;
        end
    end

    assign wb.alu_ready = alu_grant;
    assign wb.mem_ready = mem_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.reg_write  <= 1'b0;
            wb.write_addr <= '0;
            wb.write_data <= '0;
        end else begin
            // Writes to r0 are consumed but never reach the register file.
            wb.reg_write <= win_valid && (win_addr != '0);
            if (win_valid) begin
                wb.write_addr <= win_addr;
                wb.write_data <= win_data;
            end
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (wb.issue_valid && (wb.issue_addr != '0)),
        .issue_addr  (wb.issue_addr),
        .clr_valid   (wb.reg_write),
        .clr_addr    (wb.write_addr),
        .rs1_addr    (wb.rs1_addr),
        .rs2_addr    (wb.rs2_addr),
        .rs1_busy    (wb.rs1_busy),
        .rs2_busy    (wb.rs2_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal cases plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who spoke last decides priority, a set of pending registers,
    // and the single write the register file should see next cycle.
    bit          m_alu_prio;
    bit          m_busy [32];
    bit          m_rw;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          e_ag;
    bit          e_mg;

    function automatic bit exp_busy(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a];
    endfunction

    task automatic model_clear();
        m_alu_prio = 1'b1;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_rw = 1'b0;
        e_ag = 1'b0;
        e_mg = 1'b0;
    endtask

    always begin
        @(negedge clk);
        if (rst) begin
            model_clear();
            chk("rst_alu_ready",  32'(wb.alu_ready),  32'd0);
            chk("rst_mem_ready",  32'(wb.mem_ready),  32'd0);
            chk("rst_reg_write",  32'(wb.reg_write),  32'd0);
            chk("rst_write_addr", 32'(wb.write_addr), 32'd0);
            chk("rst_write_data", wb.write_data,      32'd0);
            chk("rst_rs1_busy",   32'(wb.rs1_busy),   32'd0);
            chk("rst_rs2_busy",   32'(wb.rs2_busy),   32'd0);
        end else begin
            e_ag = wb.alu_valid && (!wb.mem_valid || m_alu_prio);
            e_mg = wb.mem_valid && !e_ag;
            chk("alu_ready", 32'(wb.alu_ready), 32'(e_ag));
            chk("mem_ready", 32'(wb.mem_ready), 32'(e_mg));
            chk("reg_write", 32'(wb.reg_write), 32'(m_rw));
            if (m_rw) begin
                chk("write_addr", 32'(wb.write_addr), 32'(m_wa));
                chk("write_data", wb.write_data, m_wd);
            end
            chk("rs1_busy", 32'(wb.rs1_busy), 32'(exp_busy(wb.rs1_addr)));
            chk("rs2_busy", 32'(wb.rs2_busy), 32'(exp_busy(wb.rs2_addr)));
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (m_rw) m_busy[m_wa] = 1'b0;
            if (wb.issue_valid && wb.issue_addr != 5'd0) m_busy[wb.issue_addr] = 1'b1;
            m_rw = 1'b0;
            if (e_ag) begin
                m_rw = (wb.alu_addr != 5'd0);
                m_wa = wb.alu_addr;
                m_wd = wb.alu_data;
                m_alu_prio = 1'b0;
            end else if (e_mg) begin
                m_rw = (wb.mem_addr != 5'd0);
                m_wa = wb.mem_addr;
                m_wd = wb.mem_data;
                m_alu_prio = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit ag;
    bit mg;

    initial begin
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd3; wb.alu_data = 32'h1;
        wb.mem_valid = 1'b1; wb.mem_addr = 5'd4; wb.mem_data = 32'h2;
        wb.issue_valid = 1'b0; wb.issue_addr = '0;
        wb.rs1_addr = '0; wb.rs2_addr = '0;

        // Reset dominates even with both requesters asking.
        #2;
        chk("reset_alu_ready", 32'(wb.alu_ready), 32'd0);
        chk("reset_mem_ready", 32'(wb.mem_ready), 32'd0);
        chk("reset_reg_write", 32'(wb.reg_write), 32'd0);
        wb.alu_valid = 1'b0; wb.mem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Lone ALU request: same-cycle grant, write one cycle later, for one cycle.
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd5; wb.alu_data = 32'hDEADBEEF;
        #1;
        chk("single_alu_ready", 32'(wb.alu_ready), 32'd1);
        chk("single_mem_ready", 32'(wb.mem_ready), 32'd0);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        chk("single_reg_write", 32'(wb.reg_write), 32'd1);
        chk("single_write_addr", 32'(wb.write_addr), 32'd5);
        chk("single_write_data", wb.write_data, 32'hDEADBEEF);
        tick();
        chk("single_pulse_end", 32'(wb.reg_write), 32'd0);

        // Both valid from reset: ALU, MEM, ALU, MEM.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd1; wb.alu_data = 32'h11;
        wb.mem_valid = 1'b1; wb.mem_addr = 5'd2; wb.mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_alu_ready", 32'(wb.alu_ready), 32'(i % 2 == 0));
            chk("alt_mem_ready", 32'(wb.mem_ready), 32'(i % 2 == 1));
            chk("alt_one_hot", 32'(wb.alu_ready & wb.mem_ready), 32'd0);
            tick();
        end
        wb.alu_valid = 1'b0; wb.mem_valid = 1'b0;

        // Load to r0 is granted then dropped.
        wb.mem_valid = 1'b1; wb.mem_addr = 5'd0; wb.mem_data = 32'h1234;
        #1;
        chk("r0_mem_ready", 32'(wb.mem_ready), 32'd1);
        tick();
        wb.mem_valid = 1'b0;
        #1;
        chk("r0_reg_write", 32'(wb.reg_write), 32'd0);

        // Busy bit lifetime for r7, then a re-issue coinciding with the commit.
        wb.rs1_addr = 5'd7;
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        tick();
        wb.issue_valid = 1'b0;
        #1;
        chk("busy7_after_issue", 32'(wb.rs1_busy), 32'd1);
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd7; wb.alu_data = 32'h77;
        tick();
        wb.alu_valid = 1'b0;
        #1;
        chk("busy7_write_cycle", 32'(wb.rs1_busy), 32'd1);
        chk("busy7_reg_write", 32'(wb.reg_write), 32'd1);
        tick();
        chk("busy7_cleared", 32'(wb.rs1_busy), 32'd0);
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        tick();
        wb.issue_valid = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd7; wb.alu_data = 32'h78;
        tick();
        wb.alu_valid = 1'b0;
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        #1;
        chk("busy7_coincide_write", 32'(wb.reg_write), 32'd1);
        tick();
        wb.issue_valid = 1'b0;
        #1;
        chk("busy7_set_wins", 32'(wb.rs1_busy), 32'd1);

        // Reset in the cycle after a transfer discards the pending write.
        wb.rs2_addr = 5'd7;
        wb.alu_valid = 1'b1; wb.alu_addr = 5'd9; wb.alu_data = 32'h99;
        tick();
        wb.alu_valid = 1'b0;
        #1;
        chk("midrst_pre_write", 32'(wb.reg_write), 32'd1);
        rst = 1'b1;
        wb.alu_valid = 1'b1;
        #1;
        chk("midrst_reg_write", 32'(wb.reg_write), 32'd0);
        chk("midrst_rs2_busy", 32'(wb.rs2_busy), 32'd0);
        chk("midrst_alu_ready", 32'(wb.alu_ready), 32'd0);
        chk("midrst_write_addr", 32'(wb.write_addr), 32'd0);
        tick();
        rst = 1'b0;
        wb.alu_valid = 1'b0;
        #1;
        chk("postrst_reg_write0", 32'(wb.reg_write), 32'd0);
        tick();
        chk("postrst_reg_write1", 32'(wb.reg_write), 32'd0);

        // Issue to r0 never marks anything busy.
        wb.rs1_addr = 5'd0;
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd0;
        tick();
        wb.issue_valid = 1'b0;
        #1;
        chk("r0_never_busy", 32'(wb.rs1_busy), 32'd0);

        // Randomized traffic; requesters hold until granted, small address range for hazards.
        ag = 1'b0;
        mg = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!wb.alu_valid || ag) begin
                wb.alu_valid = ($urandom_range(0, 2) != 0);
                wb.alu_addr  = 5'($urandom_range(0, 7));
                wb.alu_data  = $urandom;
            end
            if (!wb.mem_valid || mg) begin
                wb.mem_valid = ($urandom_range(0, 2) != 0);
                wb.mem_addr  = 5'($urandom_range(0, 7));
                wb.mem_data  = $urandom;
            end
            wb.issue_valid = ($urandom_range(0, 2) == 0);
            wb.issue_addr  = 5'($urandom_range(0, 7));
            wb.rs1_addr    = 5'($urandom_range(0, 7));
            wb.rs2_addr    = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            ag = wb.alu_ready;
            mg = wb.mem_ready;
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        wb.alu_valid = 1'b0; wb.mem_valid = 1'b0; wb.issue_valid = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register-address width (32 registers).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_ready  output  1  ALU request granted this cycle.
REQ-007 alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-008 alu_data  input  DATA_WIDTH  ALU result.
REQ-009 mem_valid  input  1  load writeback request.
REQ-010 mem_ready  output  1  load request granted this cycle.
REQ-011 mem_addr  input  ADDR_WIDTH  load destination register.
REQ-012 mem_data  input  DATA_WIDTH  load result.
REQ-013 issue_valid  input  1  instruction issued that will write issue_addr.
REQ-014 issue_addr  input  ADDR_WIDTH  destination of the issued instruction.
REQ-015 rs1_addr, rs2_addr  input  ADDR_WIDTH each  source registers to hazard-check.
REQ-016 rs1_busy, rs2_busy  output  1 each  source has a pending write.
REQ-017 reg_write  output  1  register-file write enable.
REQ-018 write_addr  output  ADDR_WIDTH  register-file write address.
REQ-019 write_data  output  DATA_WIDTH  register-file write data.

Function
REQ-020 A transfer SHALL occur on a requester when its valid and ready are both high at a rising edge.
REQ-021 At most one ready SHALL be high per cycle; ready SHALL be combinational from both valids and the priority state.
REQ-022 With one requester valid, that requester SHALL receive ready in the same cycle.
REQ-023 With both valid, the requester holding priority SHALL be granted; priority FSM states PRIO_ALU, PRIO_MEM.
REQ-024 After a transfer, priority SHALL move to the requester not granted; with no transfer, priority SHALL hold.
REQ-025 A requester SHALL hold valid, addr and data stable until its transfer; the arbiter need not tolerate withdrawal.
REQ-026 A transfer SHALL produce reg_write=1 with the transferred addr/data on the registered outputs in the following cycle (latency 1), for exactly one cycle.
REQ-027 A transfer to address 0 SHALL be accepted and dropped: reg_write stays 0 in the following cycle.
REQ-028 With no transfer, reg_write SHALL be 0; write_addr/write_data SHALL hold their previous values.
REQ-029 Busy vector SHALL be ADDR_WIDTH-indexed, 2**ADDR_WIDTH bits; bit 0 permanently 0.
REQ-030 issue_valid with issue_addr != 0 SHALL set busy[issue_addr] at the edge.
REQ-031 reg_write high SHALL clear busy[write_addr] at the edge ending that cycle (same edge the register file captures the write).
REQ-032 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-033 rs1_busy/rs2_busy SHALL be combinational reads of the busy vector; address 0 always reports 0.
REQ-034 Outstanding writes to the same register SHALL NOT be counted: the first commit clears the bit.

Reset
REQ-035 rst high SHALL immediately force alu_ready=0, mem_ready=0, reg_write=0, write_addr=0, write_data=0, all busy bits=0, priority=PRIO_ALU.
REQ-036 A transfer registered before a mid-operation reset SHALL be discarded; no reg_write pulse after reset release.
REQ-037 On release, the first rising edge SHALL operate normally.

Structure
REQ-038 DATA_WIDTH/ADDR_WIDTH defaults and the priority state enumeration SHALL live in the shared CPU package.
REQ-039 The busy vector and its set/clear/lookup logic SHALL be one sub-module, wb_scoreboard; arbitration and the output register stay in the top.

Verification
REQ-040 Only alu_valid, addr 5, data 0xDEADBEEF -> alu_ready=1 same cycle; next cycle reg_write=1, write_addr=5, write_data=0xDEADBEEF.
REQ-041 Both valid for 4 cycles from reset (ALU addr 1, MEM addr 2) -> grants ALU, MEM, ALU, MEM; never both ready.
REQ-042 mem_valid addr 0, data 0x1234 -> mem_ready=1; next cycle reg_write=0.
REQ-043 issue addr 7, then ALU writeback to 7 -> rs1_busy(7)=1 until the edge ending the reg_write cycle, then 0; issue addr 7 coinciding with reg_write to 7 -> busy stays 1.
REQ-044 Assert rst the cycle after a transfer -> reg_write=0, busy all 0 immediately; no write after release.
REQ-045 issue addr 0 -> rs1_busy for rs1_addr=0 remains 0.
